// File: rtl/time_of_day_counter.sv
// Time-of-day clock: prescaled BCD hh:mm:ss counter with validated loads and 12/24-hour display.
// Define TOD_ALARM_EN to add the hh:mm alarm ports and logic.
module time_of_day_counter #(
  parameter int TICK_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        mode_12h,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [19:0] ld_time,
  output logic [19:0] time_bcd,
  output logic        pm,
  output logic        sec_tick,
  output logic        day_wrap,
  output logic        ld_err
`ifdef TOD_ALARM_EN
  ,
  input  logic        alarm_en,
  input  logic [12:0] alarm_hm,
  output logic        alarm_hit
`endif
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  typedef enum logic {RUN, CHECK} state_t;

  state_t      state, state_next;
  logic [PW-1:0] presc;
  logic [19:0] tod, tod_next, cap;
  logic        tick, wrap, cap_ok;
  logic [4:0]  hr, h12;
  logic [5:0]  disp_h;
  logic        disp_pm;

  assign tick = run && (state == RUN) && (presc == TERM);

  always_comb begin
    cap_ok = (cap[13:11] <= 3'd5) && (cap[10:7] <= 4'd9) &&
             (cap[6:4] <= 3'd5) && (cap[3:0] <= 4'd9) &&
             (((cap[19:18] < 2'd2) && (cap[17:14] <= 4'd9)) ||
              ((cap[19:18] == 2'd2) && (cap[17:14] <= 4'd3)));
  end

  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    ld_err     = 1'b0;
    case (state)
      RUN: begin
        ld_ready = 1'b1;
        if (ld_valid) state_next = CHECK;
      end
      CHECK: begin
        ld_err     = !cap_ok;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Ripple a one-second increment through the BCD digits; a valid load overrides it.
  always_comb begin
    tod_next = tod;
    wrap     = 1'b0;
    if (tick) begin
      if (tod[3:0] != 4'd9) tod_next[3:0] = tod[3:0] + 4'd1;
      else begin
        tod_next[3:0] = 4'd0;
        if (tod[6:4] != 3'd5) tod_next[6:4] = tod[6:4] + 3'd1;
        else begin
          tod_next[6:4] = 3'd0;
          if (tod[10:7] != 4'd9) tod_next[10:7] = tod[10:7] + 4'd1;
          else begin
            tod_next[10:7] = 4'd0;
            if (tod[13:11] != 3'd5) tod_next[13:11] = tod[13:11] + 3'd1;
            else begin
              tod_next[13:11] = 3'd0;
              if ((tod[19:18] == 2'd2) && (tod[17:14] == 4'd3)) begin
                tod_next[19:14] = 6'd0;
                wrap            = 1'b1;
              end else if (tod[17:14] == 4'd9) begin
                tod_next[17:14] = 4'd0;
                tod_next[19:18] = tod[19:18] + 2'd1;
              end else begin
                tod_next[17:14] = tod[17:14] + 4'd1;
              end
            end
          end
        end
      end
    end
    if ((state == CHECK) && cap_ok) tod_next = cap;
  end

  // 12-hour display remap; hours never exceed 12 there, so the tens digit is 0 or 1.
  always_comb begin
    hr      = 5'(tod_next[19:18]) * 5'd10 + 5'(tod_next[17:14]);
    h12     = hr;
    disp_h  = tod_next[19:14];
    disp_pm = 1'b0;
    if (mode_12h) begin
      if (hr == 5'd0)      h12 = 5'd12;
      else if (hr > 5'd12) h12 = hr - 5'd12;
      disp_pm = (hr >= 5'd12);
      disp_h  = (h12 >= 5'd10) ? {2'd1, 4'(h12 - 5'd10)} : {2'd0, h12[3:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      tod      <= '0;
      cap      <= '0;
      time_bcd <= '0;
      pm       <= 1'b0;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      if ((state == RUN) && ld_valid) cap <= ld_time;
      if (state == CHECK) begin
        if (cap_ok) presc <= '0;
      end else if (run) begin
        presc <= (presc == TERM) ? '0 : presc + 1'b1;
      end
      tod      <= tod_next;
      time_bcd <= {disp_h, tod_next[13:0]};
      pm       <= disp_pm;
      sec_tick <= tick;
      day_wrap <= tick && wrap;
    end
  end

`ifdef TOD_ALARM_EN
  // Only a counted second can fire the alarm, so loads landing on it stay silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm_hit <= 1'b0;
    else        alarm_hit <= tick && alarm_en && (tod_next == {alarm_hm, 7'd0});
  end
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter (TICK_DIV=4): seconds-of-day model checked every cycle,
// plus directed scenarios with literal expectations. Alarm cases build with TOD_ALARM_EN.
module tb_time_of_day_counter;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n, run, mode_12h, ld_valid;
  logic        ld_ready, pm, sec_tick, day_wrap, ld_err;
  logic [19:0] ld_time, time_bcd;
`ifdef TOD_ALARM_EN
  logic        alarm_en, alarm_hit;
  logic [12:0] alarm_hm;
`endif

  int errors = 0;
  int checks = 0;

  time_of_day_counter #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mode_12h(mode_12h),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_time(ld_time),
    .time_bcd(time_bcd), .pm(pm), .sec_tick(sec_tick),
    .day_wrap(day_wrap), .ld_err(ld_err)
`ifdef TOD_ALARM_EN
    , .alarm_en(alarm_en), .alarm_hm(alarm_hm), .alarm_hit(alarm_hit)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] tod(int h, int m, int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check_output(input string name, input logic [19:0] act, input logic [19:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: time as seconds since midnight, prescaler as a plain count.
  int   m_secs, m_pres, m_cap_secs, ch, co, mt, mo, st, so;
  bit   m_check, m_cap_ok, tk;
  logic [19:0] e_time;
  logic e_pm, e_tick, e_wrap, e_ready, e_err, e_alarm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_secs = 0; m_pres = 0; m_check = 0; m_cap_ok = 0; m_cap_secs = 0;
      e_time = '0; e_pm = 0; e_tick = 0; e_wrap = 0; e_ready = 1; e_err = 0; e_alarm = 0;
    end else begin
      tk      = run && !m_check && (m_pres == TD - 1);
      e_tick  = tk;
      e_wrap  = 0;
      e_alarm = 0;
      if (m_check) begin
        if (m_cap_ok) begin
          m_secs = m_cap_secs;
          m_pres = 0;
        end
        m_check = 0;
      end else begin
        if (run) begin
          if (m_pres == TD - 1) begin
            m_pres = 0;
            m_secs++;
            if (m_secs == 86400) begin
              m_secs = 0;
              e_wrap = 1;
            end
`ifdef TOD_ALARM_EN
            if (alarm_en && m_secs == (int'(alarm_hm[12:11]) * 10 + int'(alarm_hm[10:7])) * 3600 +
                                      (int'(alarm_hm[6:4]) * 10 + int'(alarm_hm[3:0])) * 60)
              e_alarm = 1;
`endif
          end else begin
            m_pres++;
          end
        end
        if (ld_valid) begin
          ch = ld_time[19:18]; co = ld_time[17:14]; mt = ld_time[13:11];
          mo = ld_time[10:7];  st = ld_time[6:4];   so = ld_time[3:0];
          m_cap_ok   = (co <= 9) && (mo <= 9) && (so <= 9) && (mt <= 5) && (st <= 5) &&
                       (ch * 10 + co < 24);
          m_cap_secs = (ch * 10 + co) * 3600 + (mt * 10 + mo) * 60 + st * 10 + so;
          m_check    = 1;
        end
      end
      if (mode_12h)
        e_time = tod((m_secs / 3600) % 12 == 0 ? 12 : (m_secs / 3600) % 12,
                     (m_secs / 60) % 60, m_secs % 60);
      else
        e_time = tod(m_secs / 3600, (m_secs / 60) % 60, m_secs % 60);
      e_pm    = mode_12h && (m_secs >= 43200);
      e_ready = !m_check;
      e_err   = m_check && !m_cap_ok;
    end
  end

  always @(negedge clk) begin
    check_output("model time_bcd", time_bcd, e_time);
    check_output("model pm", 20'(pm), 20'(e_pm));
    check_output("model sec_tick", 20'(sec_tick), 20'(e_tick));
    check_output("model day_wrap", 20'(day_wrap), 20'(e_wrap));
    check_output("model ld_ready", 20'(ld_ready), 20'(e_ready));
    check_output("model ld_err", 20'(ld_err), 20'(e_err));
`ifdef TOD_ALARM_EN
    check_output("model alarm_hit", 20'(alarm_hit), 20'(e_alarm));
`endif
  end

  // Called on a negedge; returns on the negedge of the CHECK cycle.
  task automatic apply_stimulus(input logic [19:0] t);
    ld_valid = 1'b1;
    ld_time  = t;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  int cnt, first_at, last_at;

  initial begin
    rst_n = 1'b0; run = 1'b0; mode_12h = 1'b0; ld_valid = 1'b0; ld_time = '0;
`ifdef TOD_ALARM_EN
    alarm_en = 1'b0; alarm_hm = '0;
`endif
    repeat (3) @(negedge clk);
    check_output("reset time_bcd", time_bcd, 20'h0);
    check_output("reset ld_ready", 20'(ld_ready), 20'h1);
    check_output("reset sec_tick", 20'(sec_tick), 20'h0);

    // Free run from reset: three ticks four cycles apart.
    rst_n = 1'b1; run = 1'b1;
    cnt = 0; first_at = -1; last_at = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sec_tick) begin
        cnt++;
        if (first_at < 0) first_at = i;
        last_at = i;
      end
    end
    run = 1'b0;
    check_output("run tick count", 20'(cnt), 20'd3);
    check_output("run first tick", 20'(first_at), 20'd3);
    check_output("run tick span", 20'(last_at - first_at), 20'd8);
    check_output("run time 00:00:03", time_bcd, tod(0, 0, 3));

    // Midnight rollover.
    apply_stimulus(tod(23, 59, 58));
    check_output("load busy ld_ready", 20'(ld_ready), 20'h0);
    @(negedge clk);
    check_output("load 23:59:58", time_bcd, tod(23, 59, 58));
    run = 1'b1; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (day_wrap) cnt++;
      if (i == 3) check_output("time 23:59:59", time_bcd, tod(23, 59, 59));
      if (i == 7) begin
        check_output("wrap time", time_bcd, 20'h0);
        check_output("wrap pulse", 20'(day_wrap), 20'h1);
      end
    end
    run = 1'b0;
    @(negedge clk);
    check_output("wrap one cycle", 20'(day_wrap), 20'h0);
    check_output("wrap count", 20'(cnt), 20'd1);

    // Rejected loads.
    apply_stimulus(tod(24, 0, 0));
    check_output("bad hour ld_err", 20'(ld_err), 20'h1);
    check_output("bad hour ld_ready", 20'(ld_ready), 20'h0);
    @(negedge clk);
    check_output("bad hour err clear", 20'(ld_err), 20'h0);
    check_output("bad hour time kept", time_bcd, 20'h0);
    apply_stimulus({2'd1, 4'd2, 3'd6, 4'd0, 3'd0, 4'd0});
    check_output("bad min ld_err", 20'(ld_err), 20'h1);
    @(negedge clk);
    check_output("bad min time kept", time_bcd, 20'h0);

    // 12-hour display.
    mode_12h = 1'b1;
    apply_stimulus(tod(0, 30, 0));
    @(negedge clk);
    check_output("12h 00:30", time_bcd, tod(12, 30, 0));
    check_output("12h 00:30 pm", 20'(pm), 20'h0);
    apply_stimulus(tod(13, 5, 0));
    @(negedge clk);
    check_output("12h 13:05", time_bcd, tod(1, 5, 0));
    check_output("12h 13:05 pm", 20'(pm), 20'h1);
    mode_12h = 1'b0;
    @(negedge clk);
    check_output("24h 13:05", time_bcd, tod(13, 5, 0));
    check_output("24h pm", 20'(pm), 20'h0);

    // Load accepted in the terminal prescaler cycle.
    run = 1'b1;
    repeat (3) @(negedge clk);
    apply_stimulus(tod(10, 0, 0));
    check_output("accept tick pulse", 20'(sec_tick), 20'h1);
    check_output("accept tick old time", time_bcd, tod(13, 5, 1));
    @(negedge clk);
    check_output("accept loaded", time_bcd, tod(10, 0, 0));
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (sec_tick) cnt++;
    end
    check_output("no early tick", 20'(cnt), 20'h0);
    @(negedge clk);
    check_output("tick after load", 20'(sec_tick), 20'h1);
    check_output("time 10:00:01", time_bcd, tod(10, 0, 1));
    run = 1'b0;

    // Reset during CHECK aborts the load.
    apply_stimulus(tod(5, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    check_output("abort ld_ready", 20'(ld_ready), 20'h1);
    check_output("abort ld_err", 20'(ld_err), 20'h0);
    check_output("abort time", time_bcd, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("abort time after", time_bcd, 20'h0);

`ifdef TOD_ALARM_EN
    alarm_hm = {2'd0, 4'd7, 3'd0, 4'd0};
    for (int pass = 0; pass < 2; pass++) begin
      alarm_en = (pass == 0);
      apply_stimulus(tod(6, 59, 58));
      @(negedge clk);
      run = 1'b1; cnt = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (alarm_hit) cnt++;
        if (i == 7 && pass == 0) check_output("alarm on tick", 20'(alarm_hit), 20'h1);
      end
      run = 1'b0;
      check_output("alarm time 07:00:00", time_bcd, tod(7, 0, 0));
      check_output("alarm hit count", 20'(cnt), (pass == 0) ? 20'd1 : 20'd0);
    end
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_of_day_counter.md
TIME_OF_DAY_COUNTER -- requirements
Module: time_of_day_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: clk cycles per second; legal range is 2 or more.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port run  input  1  1 = count seconds, 0 = hold time and prescaler.
REQ-005 SHALL have port mode_12h  input  1  display format: 1 = 12-hour, 0 = 24-hour.
REQ-006 SHALL have port ld_valid  input  1  load request.
REQ-007 SHALL have port ld_ready  output  1  load can be accepted.
REQ-008 SHALL have port ld_time  input  20  BCD time in 24-hour format, packed {hh_t[1:0],hh_o[3:0],mm_t[2:0],mm_o[3:0],ss_t[2:0],ss_o[3:0]}.
REQ-009 SHALL have port time_bcd  output  20  displayed BCD time, packed as ld_time.
REQ-010 SHALL have port pm  output  1  PM indicator; always 0 when mode_12h=0.
REQ-011 SHALL have port sec_tick  output  1  one-cycle pulse on each seconds increment.
REQ-012 SHALL have port day_wrap  output  1  one-cycle pulse on the 23:59:59 to 00:00:00 rollover.
REQ-013 SHALL have port ld_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-014 SHALL hold time internally as 24-hour BCD digits; each digit counts in BCD, never in binary.
REQ-015 SHALL use a prescaler counting 0..TICK_DIV-1 while run=1; the terminal count produces an internal tick and the prescaler returns to 0.
REQ-016 SHALL, on each tick, advance the time by one second: ss_o 9 to 0 carries into ss_t; ss 59 to 00 carries into minutes; mm 59 to 00 carries into hours; 23:59:59 goes to 00:00:00.
REQ-017 SHALL register time_bcd, sec_tick and day_wrap so that all three reflect a tick in the same cycle, one cycle after the prescaler terminal count.
REQ-018 SHALL, while run=0, freeze the prescaler value and time; no sec_tick is produced. Resuming run continues from the frozen prescaler value.
REQ-019 SHALL implement FSM states RUN and CHECK. ld_ready=1 in RUN and 0 in CHECK. A load is accepted when ld_valid=1 and ld_ready=1; the accept cycle moves the FSM to CHECK.
REQ-020 SHALL, in CHECK, validate the captured load: hours 00..23, mm_t 5 or less, ss_t 5 or less, each ones digit 9 or less. If valid, load the time and clear the prescaler. If invalid, pulse ld_err and leave the time unchanged. In both cases the FSM returns to RUN next cycle.
REQ-021 SHALL freeze the prescaler during CHECK. A tick in the accept cycle is applied to the old time; the load then overwrites it.
REQ-022 SHALL, with mode_12h=1, display hours 00 as 12 (pm=0), 01..11 unchanged (pm=0), 12 as 12 (pm=1), and 13..23 as 01..11 (pm=1). A mode change is visible on time_bcd one cycle later and never alters internal time.
REQ-023 SHALL ignore ld_valid while ld_ready=0. The request is not queued.

Reset
REQ-024 SHALL, while rst_n=0, force time to 00:00:00 and the prescaler to 0. Outputs: time_bcd=0, pm=0, sec_tick=0, day_wrap=0, ld_err=0, ld_ready=1, FSM=RUN.
REQ-025 SHALL abort a load in progress (CHECK state) on reset assertion, with no ld_err and no time update.

Configuration
REQ-026 SHALL compile in an alarm when macro TOD_ALARM_EN is defined, adding:
- inputs alarm_en (1) and alarm_hm (13, BCD {hh_t,hh_o,mm_t,mm_o}, 24-hour);
- output alarm_hit (1), a one-cycle pulse coinciding with the sec_tick that makes the time equal alarm_hm:00 while alarm_en=1.
- A load that sets time equal to the alarm does not fire it.
- alarm_hit resets to 0.
REQ-027 SHALL, without TOD_ALARM_EN, omit the alarm_en, alarm_hm and alarm_hit ports and all alarm logic.

Verification (TICK_DIV=4)
REQ-028 SHALL cover: reset release, run=1 for 12 cycles -> three sec_tick pulses, 4 cycles apart, and time_bcd shows 00:00:03.
REQ-029 SHALL cover: load 23:59:58, run 8 cycles -> 23:59:59, then 00:00:00 with day_wrap=1 for exactly one cycle.
REQ-030 SHALL cover: load 24:00:00 or 12:60:00 -> ld_err pulses one cycle after accept, ld_ready=0 for that cycle, time unchanged.
REQ-031 SHALL cover: internal time 00:30:00 and 13:05:00 with mode_12h=1 -> displays 12:30:00 pm=0 and 01:05:00 pm=1; mode_12h=0 -> 13:05:00 pm=0.
REQ-032 SHALL cover: ld_valid asserted in the prescaler terminal cycle with 10:00:00 -> tick applied to the old time, then time = 10:00:00 and the next tick 4 cycles after CHECK.
REQ-033 SHALL cover: TOD_ALARM_EN, alarm_hm=07:00, load 06:59:58 -> alarm_hit on the tick to 07:00:00; the same case with alarm_en=0 -> no hit.
